// File: rtl/culsans_exit_monitor.sv
// culsans_exit_monitor: multi-core end-of-test monitor for the Culsans SoC.
// Captures each hart's first tohost exit word (bit0 = done), aggregates
// pass/fail across all harts and enforces a cycle watchdog. The result is
// presented as a single tohost-encoded exit word.
// Optional build macro: CULSANS_EXIT_MON_FAIL_FAST_EN terminates the test on
// the first captured failing word instead of waiting for every hart.
module culsans_exit_monitor #(
    parameter int unsigned NumCores      = 2,
    parameter int unsigned ExitWidth     = 32,
    parameter int unsigned TimeoutCycles = 1_000_000,
    parameter int unsigned TimeoutCode   = 32'hDEAD,
    parameter int unsigned CntWidth      = 32,
    localparam int unsigned FcWidth      = (NumCores > 1) ? $clog2(NumCores) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumCores-1:0]           tohost_valid_i,
    input  logic [NumCores*ExitWidth-1:0] tohost_data_i,
    output logic [NumCores-1:0]           core_done_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          timeout_o,
    output logic [FcWidth-1:0]            fail_core_o,
    output logic [ExitWidth-1:0]          exit_o,
    output logic [CntWidth-1:0]           cycle_cnt_o
);

`ifdef CULSANS_EXIT_MON_FAIL_FAST_EN
    localparam bit FailFast = 1'b1;
`else
    localparam bit FailFast = 1'b0;
`endif

    localparam logic [ExitWidth-2:0] TimeoutCodeW = (ExitWidth-1)'(TimeoutCode);
    localparam logic [CntWidth-1:0]  TimeoutLast  = CntWidth'(TimeoutCycles - 1);
    localparam bit                   WatchdogOn   = (TimeoutCycles != 0);

    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t               r_state;
    logic [NumCores-1:0]  r_coreDone;
    logic [ExitWidth-1:0] r_word [NumCores];
    logic                 r_pass;
    logic                 r_timeout;
    logic [FcWidth-1:0]   r_failCore;
    logic [ExitWidth-1:0] r_exit;
    logic [CntWidth-1:0]  r_cycleCnt;

    logic [NumCores-1:0]  w_capture;
    logic [NumCores-1:0]  w_nextDone;
    logic [ExitWidth-1:0] w_nextWord [NumCores];
    logic [NumCores-1:0]  w_regFail;
    logic [NumCores-1:0]  w_nextFail;
    logic [FcWidth-1:0]   w_regIdx;
    logic [FcWidth-1:0]   w_nextIdx;
    logic [ExitWidth-1:0] w_regExit;
    logic [ExitWidth-1:0] w_nextExit;
    logic                 w_regTerm;
    logic                 w_nextTerm;
    logic                 w_expire;

    // Per-hart capture qualification and the view of captured state after this edge's captures.
    always_comb begin
        for (int i = 0; i < int'(NumCores); i++) begin
            w_capture[i]  = tohost_valid_i[i] & tohost_data_i[i*ExitWidth] & ~r_coreDone[i];
            w_nextDone[i] = r_coreDone[i] | w_capture[i];
            w_nextWord[i] = w_capture[i] ? tohost_data_i[i*ExitWidth +: ExitWidth] : r_word[i];
            w_regFail[i]  = r_coreDone[i] & (r_word[i][ExitWidth-1:1] != '0);
            w_nextFail[i] = w_nextDone[i] & (w_nextWord[i][ExitWidth-1:1] != '0);
        end
    end

    // Lowest-index failing hart, both for registered state and for the post-capture view.
    always_comb begin
        w_regIdx   = '0;
        w_regExit  = ExitWidth'(1);
        w_nextIdx  = '0;
        w_nextExit = ExitWidth'(1);
        for (int i = int'(NumCores) - 1; i >= 0; i--) begin
            if (w_regFail[i]) begin
                w_regIdx  = FcWidth'(i);
                w_regExit = r_word[i];
            end
            if (w_nextFail[i]) begin
                w_nextIdx  = FcWidth'(i);
                w_nextExit = w_nextWord[i];
            end
        end
    end

    assign w_regTerm  = (&r_coreDone) | (FailFast & (|w_regFail));
    assign w_nextTerm = (&w_nextDone) | (FailFast & (|w_nextFail));
    assign w_expire   = WatchdogOn && (r_cycleCnt == TimeoutLast);

    // Monitor FSM: capture words and count cycles in RUN, latch the verdict on entering DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_coreDone <= '0;
            for (int i = 0; i < int'(NumCores); i++) begin
                r_word[i] <= '0;
            end
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_failCore <= '0;
            r_exit     <= '0;
            r_cycleCnt <= '0;
        end else if (r_state == RUN) begin
            r_coreDone <= w_nextDone;
            for (int i = 0; i < int'(NumCores); i++) begin
                r_word[i] <= w_nextWord[i];
            end
            if (r_cycleCnt != '1) begin
                r_cycleCnt <= r_cycleCnt + CntWidth'(1);
            end
            if (w_regTerm) begin
                r_state    <= DONE;
                r_pass     <= ~(|w_regFail);
                r_exit     <= w_regExit;
                r_failCore <= w_regIdx;
            end else if (w_expire) begin
                r_state <= DONE;
                if (w_nextTerm) begin
                    r_pass     <= ~(|w_nextFail);
                    r_exit     <= w_nextExit;
                    r_failCore <= w_nextIdx;
                end else begin
                    r_timeout  <= 1'b1;
                    r_pass     <= 1'b0;
                    r_exit     <= {TimeoutCodeW, 1'b1};
                    r_failCore <= '0;
                end
            end
        end
    end

    assign core_done_o = r_coreDone;
    assign done_o      = (r_state == DONE);
    assign pass_o      = r_pass;
    assign timeout_o   = r_timeout;
    assign fail_core_o = r_failCore;
    assign exit_o      = r_exit;
    assign cycle_cnt_o = r_cycleCnt;

endmodule
